// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter: shares one single-port data RAM between the DLX data
// port (req 0) and a secondary master (req 1); round-robin with bus lock.
module dlx_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic                  lock0_i,
  input  logic                  lock1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  mem_rd_ena_o,
  output logic                  mem_wr_ena_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_LOCK);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;
  logic [7:0]            w_cnt_inc;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_own;
  logic                  w_own_req;
  logic                  w_own_lock;
  logic                  w_oth_req;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_rv;
  logic                  w_rv_id;
  logic [RD_LATENCY-1:0] r_tag_v;
  logic [RD_LATENCY-1:0] r_tag_id;

  // View of the locked owner and the waiting requester.
  assign w_own      = (r_state == ST_LOCK1);
  assign w_own_req  = w_own ? req1_i  : req0_i;
  assign w_own_lock = w_own ? lock1_i : lock0_i;
  assign w_oth_req  = w_own ? req0_i  : req1_i;
  assign w_cnt_inc  = r_cnt + 8'd1;

  // Grant decode: r_last names the last winner, the other wins a tie.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ST_ARB: begin
          if (req0_i && req1_i) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
          end else begin
            w_gnt0 = req0_i;
            w_gnt1 = req1_i;
          end
        end
        ST_LOCK0: w_gnt0 = req0_i;
        ST_LOCK1: w_gnt1 = req1_i;
        default: ;
      endcase
    end
  end

  // Next state, round-robin pointer and lock-starvation counter.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_ARB: begin
        if (w_gnt0) begin
          w_last_nxt = 1'b0;
          if (lock0_i) begin
            w_state_nxt = ST_LOCK0;
            w_cnt_nxt   = 8'd1;
          end
        end else if (w_gnt1) begin
          w_last_nxt = 1'b1;
          if (lock1_i) begin
            w_state_nxt = ST_LOCK1;
            w_cnt_nxt   = 8'd1;
          end
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (!w_own_req) begin
          w_state_nxt = ST_ARB;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_last_nxt = w_own;
          w_cnt_nxt  = w_oth_req ? w_cnt_inc : 8'd0;
          if (!w_own_lock ||
              (w_oth_req && (w_cnt_inc >= LP_MAX))) begin
            w_state_nxt = ST_ARB;
            w_cnt_nxt   = 8'd0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ARB;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_rd = (w_gnt0 & ~we0_i) | (w_gnt1 & ~we1_i);
  assign w_wr = (w_gnt0 &  we0_i) | (w_gnt1 &  we1_i);

  // Read-tag pipeline matching RAM latency; tag = (valid, requester).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= w_rd;
      r_tag_id[0] <= w_gnt1;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign w_rv    = r_tag_v[RD_LATENCY-1] & rst_n;
  assign w_rv_id = r_tag_id[RD_LATENCY-1];

  assign gnt0_o        = w_gnt0;
  assign gnt1_o        = w_gnt1;
  assign rvalid0_o     = w_rv & ~w_rv_id;
  assign rvalid1_o     = w_rv &  w_rv_id;
  assign rdata0_o      = rvalid0_o ? mem_rd_data_i : '0;
  assign rdata1_o      = rvalid1_o ? mem_rd_data_i : '0;
  assign mem_rd_ena_o  = w_rd;
  assign mem_wr_ena_o  = w_wr;
  assign mem_addr_o    = w_gnt0 ? addr0_i  :
                         w_gnt1 ? addr1_i  : '0;
  assign mem_wr_data_o = w_gnt0 ? wdata0_i :
                         w_gnt1 ? wdata1_i : '0;

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// tb_dlx_mem_arbiter: scoreboard bench with a RAM model and a
// transaction-level arbitration reference.
module tb_dlx_mem_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int RDL  = 2;
  localparam int MAXL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          d_req [2];
  logic          d_we  [2];
  logic          d_lk  [2];
  logic [AW-1:0] d_adr [2];
  logic [DW-1:0] d_wd  [2];

  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [DW-1:0] rdata0_o, rdata1_o;
  logic          mem_rd_ena_o, mem_wr_ena_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wr_data_o;
  logic [DW-1:0] mem_rd_data_i;

  dlx_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .RD_LATENCY(RDL), .MAX_LOCK(MAXL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(d_req[0]), .req1_i(d_req[1]),
    .we0_i(d_we[0]), .we1_i(d_we[1]),
    .lock0_i(d_lk[0]), .lock1_i(d_lk[1]),
    .addr0_i(d_adr[0]), .addr1_i(d_adr[1]),
    .wdata0_i(d_wd[0]), .wdata1_i(d_wd[1]),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .mem_rd_ena_o(mem_rd_ena_o), .mem_wr_ena_o(mem_wr_ena_o),
    .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_rd_data_i(mem_rd_data_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(string name, logic [127:0] got,
                     logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // RAM model: restored to its preload during reset.
  logic [DW-1:0] init_mem [64];
  logic [DW-1:0] ram      [64];
  logic [DW-1:0] rd_pipe  [RDL];
  assign mem_rd_data_i = rd_pipe[RDL-1];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_mem[i];
    end else if (mem_wr_ena_o) begin
      ram[mem_addr_o[7:2]] <= mem_wr_data_o;
    end
    for (int i = RDL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem_rd_ena_o ? ram[mem_addr_o[7:2]] : '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [DW-1:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] ref_mem [64];
  bit exp_g [2];

  // Reference: who owns the RAM this cycle and what it sees.
  always @(negedge clk) begin : model
    static int m_last = 1;
    static int m_own  = -1;
    static int m_cnt  = 0;
    int w;
    int o;
    exp_t e;
    logic [67:0] got_bus;
    logic [67:0] exp_bus;
    got_bus = {gnt0_o, gnt1_o, mem_rd_ena_o, mem_wr_ena_o,
               mem_addr_o, mem_wr_data_o};
    w = -1;
    if (!rst_n) begin
      exp_bus = '0;
      m_last = 1;
      m_own  = -1;
      m_cnt  = 0;
      sbq.delete();
      for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
    end else begin
      if (m_own < 0) begin
        if (d_req[0] && d_req[1]) w = 1 - m_last;
        else if (d_req[0])        w = 0;
        else if (d_req[1])        w = 1;
      end else if (d_req[m_own]) begin
        w = m_own;
      end
      if (w < 0) exp_bus = '0;
      else exp_bus = {w == 0, w == 1, !d_we[w], d_we[w],
                      d_adr[w], d_wd[w]};
      if (w >= 0) begin
        if (d_we[w]) begin
          ref_mem[d_adr[w][7:2]] = d_wd[w];
        end else begin
          e.id = w;
          e.data = ref_mem[d_adr[w][7:2]];
          e.due = cyc + RDL;
          sbq.push_back(e);
        end
      end
      if (m_own < 0) begin
        if (w >= 0) begin
          m_last = w;
          if (d_lk[w]) begin
            m_own = w;
            m_cnt = 1;
          end
        end
      end else begin
        o = m_own;
        if (w < 0) begin
          m_own = -1;
          m_cnt = 0;
        end else begin
          m_last = o;
          m_cnt = d_req[1-o] ? m_cnt + 1 : 0;
          if (!d_lk[o] || m_cnt >= MAXL) begin
            m_own = -1;
            m_cnt = 0;
          end
        end
      end
    end
    exp_g[0] = (w == 0);
    exp_g[1] = (w == 1);
    chk("bus", 128'(got_bus), 128'(exp_bus));
  end

  // Monitor: pops the scoreboard whenever read data is returned.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [65:0] got_rd;
    logic [65:0] exp_rd;
    got_rd = {rvalid0_o, rvalid1_o, rdata0_o, rdata1_o};
    if (!rst_n) begin
      chk("rst_rd", 128'(got_rd), 128'(0));
    end else begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        chk("rd_missing", 128'(0), 128'(e.due));
      end
      if (rvalid0_o || rvalid1_o) begin
        if (sbq.size() == 0) begin
          chk("rd_unexpected", 128'(got_rd), 128'(0));
        end else begin
          e = sbq.pop_front();
          exp_rd = {e.id == 0, e.id == 1,
                    e.id == 0 ? e.data : 32'h0,
                    e.id == 1 ? e.data : 32'h0};
          chk("rd_data", 128'(got_rd), 128'(exp_rd));
          chk("rd_time", 128'(cyc), 128'(e.due));
        end
      end else begin
        chk("rd_idle", 128'(got_rd), 128'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int n, logic r, logic we, logic lk,
                         logic [AW-1:0] a, logic [DW-1:0] d);
    d_req[n] = r;
    d_we[n]  = we;
    d_lk[n]  = lk;
    d_adr[n] = a;
    d_wd[n]  = d;
  endtask

  task automatic rnd_req(int n);
    logic [5:0] idx;
    idx = 6'($urandom_range(63));
    set_req(n, 1'b1, 1'($urandom_range(1)),
            ($urandom_range(3) == 0), {24'h0, idx, 2'b00},
            $urandom);
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] cap [5];
    logic [1:0] pat_c [4];
    logic [1:0] pat_l [5];
    pat_c = '{2'b10, 2'b01, 2'b10, 2'b01};
    pat_l = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
    init_mem[4] = 32'hDEADBEEF;
    for (int n = 0; n < 2; n++) set_req(n, 0, 0, 0, '0, '0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    set_req(0, 1, 0, 0, 32'h10, '0);
    tick();
    set_req(0, 0, 0, 0, '0, '0);
    repeat (RDL + 1) tick();

    pulse_rst();
    set_req(0, 1, 0, 0, 32'h0, '0);
    set_req(1, 1, 0, 0, 32'h4, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cap[k] = {gnt0_o, gnt1_o};
      tick();
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("contend_gnt%0d", k), 128'(cap[k]),
          128'(pat_c[k]));
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    repeat (RDL + 1) tick();

    set_req(1, 1, 1, 0, 32'h20, 32'h12345678);
    tick();
    set_req(1, 0, 0, 0, '0, '0);
    set_req(0, 1, 0, 0, 32'h20, '0);
    tick();
    set_req(0, 0, 0, 0, '0, '0);
    repeat (RDL + 1) tick();

    pulse_rst();
    set_req(0, 1, 0, 1, 32'h8, '0);
    set_req(1, 1, 0, 0, 32'hC, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cap[k] = {gnt0_o, gnt1_o};
      tick();
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("lock_gnt%0d", k), 128'(cap[k]),
          128'(pat_l[k]));
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    repeat (RDL + 1) tick();

    set_req(0, 1, 0, 0, 32'h10, '0);
    tick();
    set_req(0, 0, 0, 0, '0, '0);
    pulse_rst();
    repeat (RDL + 2) tick();

    for (int k = 0; k < 3000; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (d_req[n] && !exp_g[n]) begin
          if ($urandom_range(15) == 0) d_req[n] = 1'b0;
        end else if ($urandom_range(2) != 0) begin
          rnd_req(n);
        end else begin
          d_req[n] = 1'b0;
        end
      end
      if ($urandom_range(499) == 0) pulse_rst();
      else tick();
    end

    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    repeat (RDL + 3) tick();
    chk("sb_drained", 128'(sbq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
